// File: rtl/line_buffer_3row.sv
// Three-row line buffer: raster pixels in, vertically aligned row0/row1/row2 taps out, registered one cycle after in_valid.
// No backpressure: accepts at most one pixel per cycle, and the taps and position hold while in_valid is low.
module line_buffer_3row #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    localparam int COL_W = $clog2(IMG_W),
    localparam int ROW_W = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              pixel_valid,
    output logic [DATA_W-1:0] row0,
    output logic [DATA_W-1:0] row1,
    output logic [DATA_W-1:0] row2,
    output logic [COL_W-1:0]  out_col,
    output logic [ROW_W-1:0]  out_row,
    output logic              win_valid,
    output logic              frame_done
);
    typedef enum logic {FILL, RUN} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [DATA_W-1:0]  line_a [IMG_W];
    logic [DATA_W-1:0]  line_b [IMG_W];
    logic [DATA_W-1:0]  tap1, tap2;
    logic               last_col, last_row;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        tap1     = '0;
        tap2     = '0;
        last_col = (col_q == LAST_COL);
        last_row = (row_q == LAST_ROW);

        // Masking keys off the frame position, so stale memory from a previous frame never reaches the taps.
        if (state_q == RUN || row_q != '0)
            tap1 = line_a[col_q];
        if (state_q == RUN)
            tap2 = line_b[col_q];

        if (in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            case (state_q)
                FILL:    if (last_col && row_q == ROW_W'(1)) state_d = RUN;
                RUN:     if (last_col && last_row)           state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Line memories are never cleared; the non-blocking writes keep reads ahead of this cycle's update.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            line_b[col_q] <= line_a[col_q];
            line_a[col_q] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            row0        <= '0;
            row1        <= '0;
            row2        <= '0;
            out_col     <= '0;
            out_row     <= '0;
            win_valid   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pixel_valid <= in_valid;
            frame_done  <= in_valid && last_col && last_row;
            win_valid   <= pixel_valid && (out_row >= ROW_W'(2)) && (out_col >= COL_W'(2));
            if (in_valid) begin
                row0    <= in_pixel;
                row1    <= tap1;
                row2    <= tap2;
                out_col <= col_q;
                out_row <= row_q;
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row: 4x4 frames (continuous, back-to-back, gapped, mid-frame reset) and a 5x5 window chain.
module tb_line_buffer_3row;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid_5;
    logic [7:0] in_pixel, in_pixel_5;

    logic       pv, wv, fd;
    logic [7:0] r0, r1, r2;
    logic [1:0] oc, orw;
    logic       pv_5, wv_5, fd_5;
    logic [7:0] r0_5, r1_5, r2_5;
    logic [2:0] oc_5, orw_5;

    always #5 clk = ~clk;

    line_buffer_3row #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .pixel_valid(pv), .row0(r0), .row1(r1), .row2(r2),
        .out_col(oc), .out_row(orw), .win_valid(wv), .frame_done(fd)
    );

    line_buffer_3row #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) u_dut_5 (
        .clk(clk), .rst(rst), .in_valid(in_valid_5), .in_pixel(in_pixel_5),
        .pixel_valid(pv_5), .row0(r0_5), .row1(r1_5), .row2(r2_5),
        .out_col(oc_5), .out_row(orw_5), .win_valid(wv_5), .frame_done(fd_5)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bench-side expectation for the 4x4 instance.
    int         er, ec, hr, hc;
    logic [7:0] base, h0, h1, h2;
    bit         win_exp;
    int         n_pv, n_win, n_fd;

    task automatic step(input bit v);
        logic [7:0] pix;
        bit         fde;
        @(negedge clk);
        pix      = base + 8'(er * 16 + ec);
        in_valid = v;
        in_pixel = v ? pix : 8'($urandom);
        @(posedge clk);
        #1;
        check("pixel_valid", {31'd0, pv}, {31'd0, v});
        check("win_valid", {31'd0, wv}, {31'd0, win_exp});
        if (pv) n_pv++;
        if (wv) n_win++;
        if (fd) n_fd++;
        win_exp = v && er >= 2 && ec >= 2;
        fde = 1'b0;
        if (v) begin
            h0  = pix;
            h1  = (er >= 1) ? base + 8'((er - 1) * 16 + ec) : 8'd0;
            h2  = (er >= 2) ? base + 8'((er - 2) * 16 + ec) : 8'd0;
            hr  = er;
            hc  = ec;
            fde = (er == 3 && ec == 3);
            if (base == 8'h00 && er == 2 && ec == 3) begin
                check("tap23_row0", {24'd0, r0}, 32'h23);
                check("tap23_row1", {24'd0, r1}, 32'h13);
                check("tap23_row2", {24'd0, r2}, 32'h03);
            end
            if (base == 8'h00 && er == 1 && ec == 2) begin
                check("tap12_row1", {24'd0, r1}, 32'h02);
                check("tap12_row2", {24'd0, r2}, 32'h00);
            end
            if (base == 8'h80 && er == 2 && ec == 1) begin
                check("f2_tap21_row0", {24'd0, r0}, 32'hA1);
                check("f2_tap21_row1", {24'd0, r1}, 32'h91);
                check("f2_tap21_row2", {24'd0, r2}, 32'h81);
            end
            if (ec == 3) begin
                ec = 0;
                er = (er == 3) ? 0 : er + 1;
            end else begin
                ec++;
            end
        end
        check("row0", {24'd0, r0}, {24'd0, h0});
        check("row1", {24'd0, r1}, {24'd0, h1});
        check("row2", {24'd0, r2}, {24'd0, h2});
        check("out_col", {30'd0, oc}, 32'(hc));
        check("out_row", {30'd0, orw}, 32'(hr));
        check("frame_done", {31'd0, fd}, {31'd0, fde});
    endtask

    task automatic run_frame(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(1'b0);
            step(1'b1);
        end
    endtask

    task automatic check_counts(input string tag, input int pvs, input int wins, input int fds);
        check({tag, "_pv_count"}, 32'(n_pv), 32'(pvs));
        check({tag, "_win_count"}, 32'(n_win), 32'(wins));
        check({tag, "_fd_count"}, 32'(n_fd), 32'(fds));
        n_pv = 0; n_win = 0; n_fd = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pv"}, {31'd0, pv}, 32'd0);
        check({tag, "_taps"}, {8'd0, r0, r1, r2}, 32'd0);
        check({tag, "_pos"}, {28'd0, orw, oc}, 32'd0);
        check({tag, "_win_fd"}, {30'd0, wv, fd}, 32'd0);
    endtask

    // Reference window stage on the 5x5 instance: w[0] top (row2), w[2] bottom (row0), column 2 newest.
    logic [7:0] w [3][3];
    logic [2:0] wr, wc;
    int         n_win_5, n_fd_5;

    always @(posedge clk) begin
        if (pv_5) begin
            for (int i = 0; i < 3; i++) begin
                w[i][0] <= w[i][1];
                w[i][1] <= w[i][2];
            end
            w[0][2] <= r2_5;
            w[1][2] <= r1_5;
            w[2][2] <= r0_5;
            wr      <= orw_5;
            wc      <= oc_5;
        end
    end

    task automatic step_5(input bit v, input int r, input int c);
        @(negedge clk);
        in_valid_5 = v;
        in_pixel_5 = 8'(r * 16 + c);
        @(posedge clk);
        #1;
        if (fd_5) n_fd_5++;
        if (wv_5) begin
            n_win_5++;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    check($sformatf("win5_w%0d%0d_at_%0d_%0d", i, j, wr, wc), {24'd0, w[i][j]},
                          32'((32'(wr) - 2 + i) * 16 + (32'(wc) - 2 + j)));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pixel = 8'd0; in_valid_5 = 1'b0; in_pixel_5 = 8'd0;
        er = 0; ec = 0; hr = 0; hc = 0; base = 8'h00; h0 = 0; h1 = 0; h2 = 0;
        win_exp = 1'b0; n_pv = 0; n_win = 0; n_fd = 0; n_win_5 = 0; n_fd_5 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_frame(1'b0);
        step(1'b0);
        check_counts("frame1", 16, 4, 1);

        run_frame(1'b0);
        base = 8'h80;
        run_frame(1'b0);
        step(1'b0);
        check_counts("b2b", 32, 8, 2);

        base = 8'h00;
        run_frame(1'b1);
        repeat (3) step(1'b0);
        check_counts("gaps", 16, 4, 1);

        for (int i = 0; i < 10; i++) step(1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_pixel = 8'hEE;
        @(posedge clk);
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        er = 0; ec = 0; hr = 0; hc = 0; h0 = 0; h1 = 0; h2 = 0; win_exp = 1'b0;
        n_pv = 0; n_win = 0; n_fd = 0;
        step(1'b0);
        run_frame(1'b0);
        step(1'b0);
        check_counts("restart", 16, 4, 1);

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                step_5(1'b1, r, c);
        step_5(1'b0, 0, 0);
        step_5(1'b0, 0, 0);
        check("win5_count", 32'(n_win_5), 32'd9);
        check("win5_fd_count", 32'(n_fd_5), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
